uart_tx_mmio: RTL and testbench



---
 rtl/uart_tx_mmio.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO and a pollable STATUS register.
// Define UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR    = 32'h1001_0400,
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic        Tx,
    output logic        Busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   DEPTH     = (PW + 1)'(FIFO_DEPTH);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, PARITY = 3'd4} state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`else
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;
`endif

    state_t        state_r;
    logic          tx_r;
    logic [CW-1:0] baud_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   count_r;
    logic          overflow_r;

    logic       sel_data_s;
    logic       sel_stat_s;
    logic       full_s;
    logic       empty_s;
    logic       fsm_busy_s;
    logic       push_req_s;
    logic       push_s;
    logic       pop_s;
    logic       baud_end_s;
    logic [3:0] count4_s;
    logic [7:0] head_s;
    logic [31:0] read_data_s;
    logic       unused_s;

    assign sel_data_s = (Address[31:2] == BASE_ADDR[31:2]);
    assign sel_stat_s = (Address[31:2] == (BASE_ADDR[31:2] + 30'd1));
    assign full_s     = (count_r == DEPTH);
    assign empty_s    = (count_r == '0);
    assign fsm_busy_s = (state_r != IDLE);
    assign push_req_s = MemWrite && sel_data_s;
    assign push_s     = push_req_s && !full_s;
    assign baud_end_s = (baud_r == BAUD_LAST);
    assign count4_s   = 4'(count_r);
    assign head_s     = mem_r[rd_ptr_r];
    assign unused_s   = ^{Address[1:0], WriteData[31:8]};

    assign Tx       = tx_r;
    assign Busy     = fsm_busy_s | ~empty_s;
    assign ReadData = read_data_s;

    // Pop request: IDLE takes a byte as soon as one is queued; STOP chains the next byte without a gap.
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            IDLE:    pop_s = !empty_s;
            STOP:    pop_s = baud_end_s && !empty_s;
            default: pop_s = 1'b0;
        endcase
    end

    // Status read mux; TXDATA and unselected addresses read as zero.
    always_comb begin
        read_data_s = 32'd0;
        if (MemRead && sel_stat_s) begin
            read_data_s = {24'd0, count4_s, overflow_r, fsm_busy_s, empty_s, full_s};
        end else begin
            read_data_s = 32'd0;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'd0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= WriteData[7:0];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since the depth is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PW + 1)'(1);
                2'b01:   count_r <= count_r - (PW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow: a store to a full FIFO is dropped even if a pop happens on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r <= 1'b0;
        end else if (push_req_s && full_s) begin
            overflow_r <= 1'b1;
        end else if (MemWrite && sel_stat_s && WriteData[3]) begin
            overflow_r <= 1'b0;
        end
    end

    // Serialiser FSM; Tx is registered and changes on the same edge as the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            tx_r      <= 1'b1;
            baud_r    <= '0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    baud_r    <= '0;
                    bit_idx_r <= 3'd0;
                    if (pop_s) begin
                        shift_r <= head_s;
                        state_r <= START;
                        tx_r    <= 1'b0;
                    end else begin
                        tx_r <= 1'b1;
                    end
                end
                START: begin
                    if (baud_end_s) begin
                        baud_r    <= '0;
                        bit_idx_r <= 3'd0;
                        tx_r      <= shift_r[0];
                        state_r   <= DATA;
                    end else begin
                        baud_r <= baud_r + CW'(1);
                    end
                end
                DATA: begin
                    if (baud_end_s) begin
                        baud_r <= '0;
                        if (bit_idx_r == 3'd7) begin
`ifdef UART_PARITY_EN
                            state_r <= PARITY;
                            tx_r    <= even_parity(shift_r);
`else
                            state_r <= STOP;
                            tx_r    <= 1'b1;
`endif
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            tx_r      <= shift_r[bit_idx_r + 3'd1];
                        end
                    end else begin
                        baud_r <= baud_r + CW'(1);
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (baud_end_s) begin
                        baud_r  <= '0;
                        state_r <= STOP;
                        tx_r    <= 1'b1;
                    end else begin
                        baud_r <= baud_r + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (baud_end_s) begin
                        baud_r    <= '0;
                        bit_idx_r <= 3'd0;
                        if (pop_s) begin
                            shift_r <= head_s;
                            state_r <= START;
                            tx_r    <= 1'b0;
                        end else begin
                            state_r <= IDLE;
                            tx_r    <= 1'b1;
                        end
                    end else begin
                        baud_r <= baud_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    tx_r    <= 1'b1;
                    baud_r  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: decode vector table plus per-cycle frame checks.
// Build with UART_PARITY_EN defined to exercise the parity frame.
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE = 32'h1001_0400;
    localparam logic [31:0] STAT = 32'h1001_0404;
    localparam int CPB = 4;
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        Tx;
    logic        Busy;

    int tests = 0;
    int fails = 0;

    uart_tx_mmio #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData), .Tx(Tx), .Busy(Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        mw;
        logic        mr;
        logic [31:0] exp_rd;
        logic        exp_busy;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        Address = 32'd0; WriteData = 32'd0; MemWrite = 1'b0; MemRead = 1'b0;
    endtask

    task automatic read_status();
        Address = STAT; MemWrite = 1'b0; MemRead = 1'b1;
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        Address = addr; WriteData = data; MemWrite = 1'b1; MemRead = 1'b0;
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    task automatic wait_start();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (Tx === 1'b0) found = 1'b1;
            else @(negedge clk);
        end
        check("start_seen", 32'(found), 32'd1);
    endtask

    // Checks Tx on every cycle of one frame, starting at the first negedge of the start bit.
    task automatic check_frame(input logic [7:0] b, input string tag);
        int   k;
        logic e;
        for (int i = 0; i < NBITS * CPB; i++) begin
            k = i / CPB;
            if (k == 0)                    e = 1'b0;
            else if (k <= 8)               e = b[k-1];
            else if (k == 9 && NBITS == 11) e = ^b;
            else                           e = 1'b1;
            check($sformatf("%s_cyc%0d", tag, i), 32'(Tx), 32'(e));
            if (i == NBITS * CPB - 1) check($sformatf("%s_busy_last", tag), 32'(Busy), 32'd1);
            @(negedge clk);
        end
    endtask

    vec_t vecs [10];

    initial begin
        vecs[0] = '{STAT,          32'd0,   1'b0, 1'b1, 32'h2, 1'b0};
        vecs[1] = '{BASE,          32'd0,   1'b0, 1'b1, 32'h0, 1'b0};
        vecs[2] = '{BASE + 32'd8,  32'd0,   1'b0, 1'b1, 32'h0, 1'b0};
        vecs[3] = '{BASE - 32'd4,  32'd0,   1'b0, 1'b1, 32'h0, 1'b0};
        vecs[4] = '{BASE + 32'd6,  32'd0,   1'b0, 1'b1, 32'h2, 1'b0};
        vecs[5] = '{STAT,          32'd0,   1'b0, 1'b0, 32'h0, 1'b0};
        vecs[6] = '{BASE + 32'd8,  32'hA5,  1'b1, 1'b0, 32'h0, 1'b0};
        vecs[7] = '{STAT,          32'hFF,  1'b1, 1'b0, 32'h0, 1'b0};
        vecs[8] = '{STAT,          32'd0,   1'b0, 1'b1, 32'h2, 1'b0};
        vecs[9] = '{STAT,          32'd0,   1'b1, 1'b1, 32'h2, 1'b0};

        reset = 1'b0;
        bus_idle();
        repeat (2) @(negedge clk);
        read_status();
        check("reset_tx", 32'(Tx), 32'd1);
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_status", ReadData, 32'h2);
        reset = 1'b1;
        bus_idle();
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            Address = vecs[i].addr; WriteData = vecs[i].wdata;
            MemWrite = vecs[i].mw; MemRead = vecs[i].mr;
            #1;
            check($sformatf("vec%0d_rd", i), ReadData, vecs[i].exp_rd);
            @(negedge clk);
            check($sformatf("vec%0d_busy", i), 32'(Busy), 32'(vecs[i].exp_busy));
        end
        bus_idle();
        @(negedge clk);

        // Single byte
        store(BASE, 32'hA5);
        read_status();
        check("single_status_queued", ReadData, 32'h10);
        check("single_busy_queued", 32'(Busy), 32'd1);
        wait_start();
        check_frame(8'hA5, "single");
        check("single_tx_end", 32'(Tx), 32'd1);
        check("single_busy_end", 32'(Busy), 32'd0);
        check("single_status_end", ReadData, 32'h2);
        bus_idle();
        @(negedge clk);

        // Back-to-back: second start bit exactly one frame after the first
        store(BASE, 32'h01);
        store(BASE, 32'h02);
        read_status();
        check("b2b_status_second", ReadData, 32'h14);
        check("b2b_tx_started", 32'(Tx), 32'd0);
        check_frame(8'h01, "b2b_first");
        check("b2b_status_mid", ReadData, 32'h6);
        check_frame(8'h02, "b2b_second");
        check("b2b_busy_end", 32'(Busy), 32'd0);
        check("b2b_status_end", ReadData, 32'h2);
        bus_idle();
        @(negedge clk);

        // Overflow: 6 stores, first goes in flight, 4 queue, last dropped
        store(BASE, 32'h11);
        store(BASE, 32'h22);
        store(BASE, 32'h33);
        store(BASE, 32'h44);
        store(BASE, 32'h55);
        store(BASE, 32'h66);
        read_status();
        check("ovf_status_set", ReadData, 32'h4D);
        store(STAT, 32'h8);
        read_status();
        check("ovf_status_clr", ReadData, 32'h45);
        repeat (NBITS * CPB - 5) @(negedge clk);
        check_frame(8'h22, "ovf_b1");
        check_frame(8'h33, "ovf_b2");
        check_frame(8'h44, "ovf_b3");
        check_frame(8'h55, "ovf_b4");
        check("ovf_busy_end", 32'(Busy), 32'd0);
        check("ovf_tx_end", 32'(Tx), 32'd1);
        check("ovf_status_end", ReadData, 32'h2);
        bus_idle();
        @(negedge clk);

        // Reset during DATA bit 3 with another byte still queued
        store(BASE, 32'hC3);
        store(BASE, 32'h5A);
        repeat (17) @(negedge clk);
        check("rst_mid_tx_before", 32'(Tx), 32'd0);
        reset = 1'b0;
        #1;
        check("rst_mid_tx", 32'(Tx), 32'd1);
        check("rst_mid_busy", 32'(Busy), 32'd0);
        read_status();
        check("rst_mid_status", ReadData, 32'h2);
        @(negedge clk);
        reset = 1'b1;
        bus_idle();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            check($sformatf("rst_quiet_%0d", i), 32'(Tx), 32'd1);
        end
        read_status();
        check("rst_after_status", ReadData, 32'h2);
        bus_idle();
        @(negedge clk);

`ifdef UART_PARITY_EN
        store(BASE, 32'h07);
        wait_start();
        check_frame(8'h07, "par07");
        check("par07_busy_end", 32'(Busy), 32'd0);
        store(BASE, 32'h03);
        wait_start();
        check_frame(8'h03, "par03");
        check("par03_busy_end", 32'(Busy), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
